// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the fetch/data memory port arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int MEM_LAT_MAX = 7;
  localparam int LAT_W       = $clog2(MEM_LAT_MAX + 1);
  localparam int CNT_W       = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;
endpackage

// File: rtl/mem_arb_pick.sv
// Priority pick between fetch and data requests; combinational, zero latency.
// Data wins unless fetch has lost STARVE_MAX arbitrations in a row.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 2
) (
  input  logic             if_req,
  input  logic             dm_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             pick_vld,
  output owner_t           pick_owner
);

  always_comb begin
    pick_vld   = if_req | dm_req;
    pick_owner = OWN_DM;
    if (if_req && (!dm_req || starve_cnt == CNT_W'(STARVE_MAX))) begin
      pick_owner = OWN_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and load/store; loads respond MEM_LAT+2 cycles after sampling, stores 2.
// Requests are only sampled in IDLE/RESP; a losing requester holds req and is protected by the starvation guard.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_grant,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_grant,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t           state, nxt_state;
  owner_t           owner, nxt_owner;
  logic [LAT_W-1:0] lat_cnt, nxt_lat;
  logic [CNT_W-1:0] starve_cnt, nxt_starve;
  logic             pick_vld;
  owner_t           pick_owner;

  logic              nxt_if_grant, nxt_if_rvalid, nxt_dm_grant, nxt_dm_rvalid;
  logic              nxt_mem_en, nxt_mem_we, nxt_busy;
  logic [ADDR_W-1:0] nxt_mem_addr;
  logic [DATA_W-1:0] nxt_mem_wdata, nxt_if_rdata, nxt_dm_rdata;

  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .starve_cnt (starve_cnt),
    .pick_vld   (pick_vld),
    .pick_owner (pick_owner)
  );

  always_comb begin
    nxt_state     = state;
    nxt_owner     = owner;
    nxt_lat       = lat_cnt;
    nxt_starve    = starve_cnt;
    nxt_if_grant  = 1'b0;
    nxt_dm_grant  = 1'b0;
    nxt_if_rvalid = 1'b0;
    nxt_dm_rvalid = 1'b0;
    nxt_mem_en    = 1'b0;
    nxt_mem_we    = mem_we;
    nxt_mem_addr  = mem_addr;
    nxt_mem_wdata = mem_wdata;
    nxt_if_rdata  = if_rdata;
    nxt_dm_rdata  = dm_rdata;

    case (state)
      IDLE, RESP: begin
        nxt_state = IDLE;
        if (!if_req || (pick_vld && pick_owner == OWN_IF)) begin
          nxt_starve = '0;
        end else if (starve_cnt != CNT_W'(STARVE_MAX)) begin
          nxt_starve = starve_cnt + CNT_W'(1);
        end
        if (pick_vld) begin
          nxt_state  = ISSUE;
          nxt_owner  = pick_owner;
          nxt_mem_en = 1'b1;
          if (pick_owner == OWN_IF) begin
            nxt_if_grant = 1'b1;
            nxt_mem_we   = 1'b0;
            nxt_mem_addr = if_addr;
          end else begin
            nxt_dm_grant  = 1'b1;
            nxt_mem_we    = dm_write;
            nxt_mem_addr  = dm_addr;
            nxt_mem_wdata = dm_wdata;
          end
        end
      end
      ISSUE: begin
        // Stores are done once the strobe has been seen; only data port can store.
        if (mem_we) begin
          nxt_state     = RESP;
          nxt_dm_rvalid = 1'b1;
          nxt_dm_rdata  = '0;
        end else begin
          nxt_state = WAIT;
          nxt_lat   = LAT_W'(MEM_LAT - 1);
        end
      end
      WAIT: begin
        if (lat_cnt == '0) begin
          nxt_state = RESP;
          if (owner == OWN_IF) begin
            nxt_if_rvalid = 1'b1;
            nxt_if_rdata  = mem_rdata;
          end else begin
            nxt_dm_rvalid = 1'b1;
            nxt_dm_rdata  = mem_rdata;
          end
        end else begin
          nxt_lat = lat_cnt - LAT_W'(1);
        end
      end
    endcase

    nxt_busy = (nxt_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      if_grant   <= 1'b0;
      dm_grant   <= 1'b0;
      if_rvalid  <= 1'b0;
      dm_rvalid  <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= nxt_state;
      owner      <= nxt_owner;
      lat_cnt    <= nxt_lat;
      starve_cnt <= nxt_starve;
      if_grant   <= nxt_if_grant;
      dm_grant   <= nxt_dm_grant;
      if_rvalid  <= nxt_if_rvalid;
      dm_rvalid  <= nxt_dm_rvalid;
      mem_en     <= nxt_mem_en;
      mem_we     <= nxt_mem_we;
      mem_addr   <= nxt_mem_addr;
      mem_wdata  <= nxt_mem_wdata;
      if_rdata   <= nxt_if_rdata;
      dm_rdata   <= nxt_dm_rdata;
      busy       <= nxt_busy;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: four arbiter instances (MEM_LAT 1,2,3,7) each with a latency-exact memory model.
module tb_mem_port_arbiter;

  localparam int NDUT = 4;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        if_req    [NDUT];
  logic [31:0] if_addr   [NDUT];
  logic        if_grant  [NDUT];
  logic        if_rvalid [NDUT];
  logic [31:0] if_rdata  [NDUT];
  logic        dm_req    [NDUT];
  logic        dm_write  [NDUT];
  logic [31:0] dm_addr   [NDUT];
  logic [31:0] dm_wdata  [NDUT];
  logic        dm_grant  [NDUT];
  logic        dm_rvalid [NDUT];
  logic [31:0] dm_rdata  [NDUT];
  logic        mem_en    [NDUT];
  logic        mem_we    [NDUT];
  logic [31:0] mem_addr  [NDUT];
  logic [31:0] mem_wdata [NDUT];
  logic [31:0] mem_rdata [NDUT];
  logic        busy      [NDUT];

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : (32'hC0DE0000 | a);
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : gd
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 7;

    logic [31:0] mem_q [64];
    bit          wr_q  [64];
    bit          pv    [8];
    logic [31:0] pd    [8];
    logic [5:0]  idx;
    logic [31:0] rd_now;

    assign idx          = mem_addr[g][7:2];
    assign rd_now       = wr_q[idx] ? mem_q[idx] : mem_init({24'd0, idx, 2'b00});
    // Data is only presented in the one cycle a correct MEM_LAT sampler would use.
    assign mem_rdata[g] = pv[L-1] ? pd[L-1] : 32'hBAD0BAD0;

    always @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < 64; k++) wr_q[k] <= 1'b0;
      end else if (mem_en[g] && mem_we[g]) begin
        mem_q[idx] <= mem_wdata[g];
        wr_q[idx]  <= 1'b1;
      end
      pv[0] <= mem_en[g] && !mem_we[g];
      pd[0] <= rd_now;
      for (int k = 1; k < 8; k++) begin
        pv[k] <= pv[k-1];
        pd[k] <= pd[k-1];
      end
    end

    mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT(L), .STARVE_MAX(2)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req[g]),
      .if_addr   (if_addr[g]),
      .if_grant  (if_grant[g]),
      .if_rvalid (if_rvalid[g]),
      .if_rdata  (if_rdata[g]),
      .dm_req    (dm_req[g]),
      .dm_write  (dm_write[g]),
      .dm_addr   (dm_addr[g]),
      .dm_wdata  (dm_wdata[g]),
      .dm_grant  (dm_grant[g]),
      .dm_rvalid (dm_rvalid[g]),
      .dm_rdata  (dm_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .busy      (busy[g])
    );
  end

  typedef struct {
    int          t_g;
    int          t_r;
    int          en_n;
    int          busy_n;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    bit          other_rv;
  } res_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cycle numbers are relative to the sampling edge T: value k means cycle T+k.
  task automatic access(input int i, input bit fetch, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, output res_t r);
    int t0;
    t0 = cyc;
    r = '{t_g: -1, t_r: -1, en_n: 0, busy_n: 0, we: 1'b0, addr: '0, wdata: '0, rd: '0, other_rv: 1'b0};
    if (fetch) begin
      if_req[i]  = 1'b1;
      if_addr[i] = a;
    end else begin
      dm_req[i]   = 1'b1;
      dm_write[i] = wr;
      dm_addr[i]  = a;
      dm_wdata[i] = wd;
    end
    for (int n = 0; n < 30 && r.t_r < 0; n++) begin
      @(negedge clk);
      if (mem_en[i]) r.en_n++;
      if (busy[i]) r.busy_n++;
      if (fetch ? if_grant[i] : dm_grant[i]) begin
        r.t_g   = cyc - t0;
        r.we    = mem_we[i];
        r.addr  = mem_addr[i];
        r.wdata = mem_wdata[i];
        if (fetch) if_req[i] = 1'b0; else dm_req[i] = 1'b0;
      end
      if (fetch ? if_rvalid[i] : dm_rvalid[i]) begin
        r.t_r = cyc - t0;
        r.rd  = fetch ? if_rdata[i] : dm_rdata[i];
      end
      if (fetch ? dm_rvalid[i] : if_rvalid[i]) r.other_rv = 1'b1;
    end
    if (fetch) if_req[i] = 1'b0; else dm_req[i] = 1'b0;
  endtask

  res_t r, r2;
  int   c1, c2;
  bit   seen;
  int   order [6];
  int   exp_order [6];
  int   ng, smax;

  initial begin
    exp_order = '{1, 1, 0, 1, 1, 0};
    rst = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      if_req[i] = 1'b0; if_addr[i] = '0; dm_req[i] = 1'b0; dm_write[i] = 1'b0;
      dm_addr[i] = '0; dm_wdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ctrl", {25'd0, if_grant[0], if_rvalid[0], dm_grant[0], dm_rvalid[0],
                       mem_en[0], mem_we[0], busy[0]}, 32'd0);
    check("rst_mem_addr", mem_addr[0], 32'd0);
    check("rst_mem_wdata", mem_wdata[0], 32'd0);
    check("rst_if_rdata", if_rdata[0], 32'd0);
    check("rst_dm_rdata", dm_rdata[0], 32'd0);

    // Data load, MEM_LAT=2
    access(1, 1'b0, 1'b0, 32'h40, 32'd0, r);
    check("ld_grant_t", r.t_g, 1);
    check("ld_we", r.we, 1'b0);
    check("ld_addr", r.addr, 32'h40);
    check("ld_en_count", r.en_n, 1);
    check("ld_rvalid_t", r.t_r, 4);
    check("ld_rdata", r.rd, 32'hDEADBEEF);
    check("ld_if_rvalid", r.other_rv, 1'b0);

    // Store, MEM_LAT=1, then fetch reads it back
    access(0, 1'b0, 1'b1, 32'h10, 32'h12345678, r);
    check("st_grant_t", r.t_g, 1);
    check("st_we", r.we, 1'b1);
    check("st_addr", r.addr, 32'h10);
    check("st_wdata", r.wdata, 32'h12345678);
    check("st_rvalid_t", r.t_r, 2);
    check("st_rdata", r.rd, 32'd0);
    access(0, 1'b1, 1'b0, 32'h10, 32'd0, r);
    check("rb_rvalid_t", r.t_r, 3);
    check("rb_rdata", r.rd, 32'h12345678);
    check("rb_dm_rdata_held", dm_rdata[0], 32'd0);

    // Back-to-back fetch loads, MEM_LAT=1
    @(negedge clk);
    c1 = cyc;
    access(0, 1'b1, 1'b0, 32'h0, 32'd0, r);
    c2 = cyc;
    access(0, 1'b1, 1'b0, 32'h4, 32'd0, r2);
    check("b2b_first_t", r.t_r, 3);
    check("b2b_first_data", r.rd, 32'hC0DE0000);
    check("b2b_gap", c2 - c1, 3);
    check("b2b_second_t", r2.t_r, 3);
    check("b2b_second_data", r2.rd, 32'hC0DE0004);
    check("b2b_en_count", r.en_n + r2.en_n, 2);

    // Both requesters held continuously, data stores
    @(negedge clk);
    if_req[0] = 1'b1; if_addr[0] = 32'h8;
    dm_req[0] = 1'b1; dm_write[0] = 1'b1; dm_addr[0] = 32'h20; dm_wdata[0] = 32'hA5A5A5A5;
    ng = 0; smax = 0;
    for (int n = 0; n < 80 && ng < 6; n++) begin
      @(negedge clk);
      if (int'(gd[0].u_dut.starve_cnt) > smax) smax = int'(gd[0].u_dut.starve_cnt);
      if (if_grant[0]) begin order[ng] = 0; ng++; end
      if (dm_grant[0] && ng < 6) begin order[ng] = 1; ng++; end
    end
    if_req[0] = 1'b0; dm_req[0] = 1'b0;
    check("arb_grants", ng, 6);
    for (int k = 0; k < 6; k++) check($sformatf("arb_order%0d", k), order[k], exp_order[k]);
    check("starve_max", smax, 2);
    repeat (6) @(negedge clk);
    check("arb_idle", busy[0], 1'b0);

    // Reset during WAIT of a MEM_LAT=3 load
    access(2, 1'b0, 1'b0, 32'h8, 32'd0, r);
    check("pre_rst_rdata", r.rd, 32'hC0DE0008);
    dm_req[2] = 1'b1; dm_write[2] = 1'b0; dm_addr[2] = 32'h40;
    @(negedge clk);
    check("abort_grant", dm_grant[2], 1'b1);
    dm_req[2] = 1'b0;
    @(negedge clk);
    check("abort_busy_wait", busy[2], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ctrl", {25'd0, if_grant[2], if_rvalid[2], dm_grant[2], dm_rvalid[2],
                         mem_en[2], mem_we[2], busy[2]}, 32'd0);
    check("abort_mem_addr", mem_addr[2], 32'd0);
    check("abort_dm_rdata", dm_rdata[2], 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (dm_rvalid[2] || if_rvalid[2]) seen = 1'b1;
    end
    check("abort_no_rvalid", seen, 1'b0);
    access(2, 1'b0, 1'b0, 32'h40, 32'd0, r);
    check("post_rst_t", r.t_r, 5);
    check("post_rst_rdata", r.rd, 32'hDEADBEEF);

    // MEM_LAT=7 fetch load
    access(3, 1'b1, 1'b0, 32'h24, 32'd0, r);
    check("lat7_grant_t", r.t_g, 1);
    check("lat7_rvalid_t", r.t_r, 9);
    check("lat7_rdata", r.rd, 32'hC0DE0024);
    check("lat7_en_count", r.en_n, 1);
    check("lat7_busy_cycles", r.busy_n, 9);
    @(negedge clk);
    check("lat7_busy_after", busy[3], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
